// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM state definitions for the ALU execute stage.
package alu_pkg;

  localparam logic [1:0] OP_SUB    = 2'b00;
  localparam logic [1:0] OP_NAND   = 2'b01;
  localparam logic [1:0] OP_LONES  = 2'b10;
  localparam logic [1:0] OP_ONEHOT = 2'b11;

  localparam int unsigned FLG_ZERO = 0;
  localparam int unsigned FLG_NEG  = 1;
  localparam int unsigned FLG_OVF  = 2;
  localparam int unsigned FLG_ERR  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_bit_scanner.sv
// Serial MSB-first scanner over {B,A}: leading-ones count (mode 0) or
// lowest-set-bit index with multiple-ones error (mode 1).
module alu_bit_scanner #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 i_CLK,
  input  logic                 i_RSTn,
  input  logic                 i_START,
  input  logic                 i_MODE,
  input  logic [2*WIDTH-1:0]   i_VEC,
  output logic                 o_DONE,
  output logic [WIDTH-1:0]     o_COUNT,
  output logic                 o_ERR
);

  localparam int unsigned IW = $clog2(2 * WIDTH);

  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_count;
  logic             r_seen;
  logic             r_err;
  logic             w_bit;
  logic             w_last;

  // Outputs are this cycle's result so the caller can latch them on the done edge.
  always_comb begin
    w_bit   = i_VEC[r_idx];
    w_last  = (r_idx == '0);
    o_DONE  = w_last;
    o_COUNT = r_count;
    o_ERR   = r_err;
    if (i_MODE) begin
      o_COUNT = w_bit ? WIDTH'(r_idx) : r_count;
      o_ERR   = r_err | (w_bit & r_seen);
    end else begin
      o_DONE  = ~w_bit | w_last;
      o_COUNT = r_count + WIDTH'(w_bit);
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_idx   <= '0;
      r_count <= '0;
      r_seen  <= 1'b0;
      r_err   <= 1'b0;
    end else if (i_START) begin
      r_idx   <= IW'(2 * WIDTH - 1);
      r_count <= '0;
      r_seen  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (!w_last) r_idx <= r_idx - 1'b1;
      r_count <= o_COUNT;
      r_err   <= o_ERR;
      r_seen  <= r_seen | w_bit;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage with ready/valid handshake. Define ALU_SERIAL_EN to run
// LONES/ONEHOT as a one-bit-per-cycle scan; otherwise they complete in one cycle.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic             i_VALID,
  output logic             o_READY,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic [1:0]       i_OP,
  output logic             o_VALID,
  input  logic             i_READY,
  output logic [WIDTH-1:0] o_Y,
  output logic [3:0]       o_FLAGS
);

  state_t           r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_y;
  logic [3:0]       r_flags;

  logic             w_accept;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_imm_y;
  logic             w_imm_ovf;
  logic             w_imm_neg_en;
  logic             w_imm_err;
  logic [3:0]       w_imm_flags;

  function automatic logic [3:0] f_flags(input logic [WIDTH-1:0] y, input logic neg_en,
                                         input logic ovf, input logic err);
    logic [3:0] f;
    f           = '0;
    f[FLG_ZERO] = (y == '0);
    f[FLG_NEG]  = neg_en & y[WIDTH-1];
    f[FLG_OVF]  = ovf;
    f[FLG_ERR]  = err;
    return f;
  endfunction

`ifndef ALU_SERIAL_EN
  function automatic logic [WIDTH-1:0] f_lones(input logic [2*WIDTH-1:0] c);
    logic             run;
    logic [WIDTH-1:0] n;
    run = 1'b1;
    n   = '0;
    for (int unsigned i = 0; i < 2 * WIDTH; i++) begin
      if (run && c[2*WIDTH-1-i]) n = n + 1'b1;
      else run = 1'b0;
    end
    return n;
  endfunction

  // Ascending search: first hit is the lowest set bit, any further hit is an error.
  function automatic logic [WIDTH:0] f_onehot(input logic [2*WIDTH-1:0] c);
    logic             seen;
    logic             err;
    logic [WIDTH-1:0] y;
    seen = 1'b0;
    err  = 1'b0;
    y    = '0;
    for (int unsigned i = 0; i < 2 * WIDTH; i++) begin
      if (c[i]) begin
        if (seen) err = 1'b1;
        else y = WIDTH'(i);
        seen = 1'b1;
      end
    end
    return {err, y};
  endfunction
`endif

  assign o_READY  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & i_READY);
  assign o_VALID  = r_valid;
  assign o_Y      = r_y;
  assign o_FLAGS  = r_flags;
  assign w_accept = i_VALID & o_READY;

  always_comb begin
    w_diff       = i_A - i_B;
    w_imm_y      = w_diff;
    w_imm_ovf    = (i_A[WIDTH-1] ^ i_B[WIDTH-1]) & (w_diff[WIDTH-1] ^ i_A[WIDTH-1]);
    w_imm_neg_en = 1'b1;
    w_imm_err    = 1'b0;
    case (i_OP)
      OP_NAND: begin
        w_imm_y   = ~(i_A & i_B);
        w_imm_ovf = 1'b0;
      end
`ifndef ALU_SERIAL_EN
      OP_LONES: begin
        w_imm_y      = f_lones({i_B, i_A});
        w_imm_ovf    = 1'b0;
        w_imm_neg_en = 1'b0;
      end
      OP_ONEHOT: begin
        {w_imm_err, w_imm_y} = f_onehot({i_B, i_A});
        w_imm_ovf    = 1'b0;
        w_imm_neg_en = 1'b0;
      end
`endif
      default: ;
    endcase
    w_imm_flags = f_flags(w_imm_y, w_imm_neg_en, w_imm_ovf, w_imm_err);
  end

`ifdef ALU_SERIAL_EN
  logic [1:0]         r_op;
  logic [2*WIDTH-1:0] r_vec;
  logic               w_is_scan;
  logic               w_start;
  logic               w_scan_done;
  logic [WIDTH-1:0]   w_scan_count;
  logic               w_scan_err;

  assign w_is_scan = (i_OP == OP_LONES) | (i_OP == OP_ONEHOT);
  assign w_start   = w_accept & w_is_scan;

  alu_bit_scanner #(.WIDTH(WIDTH)) u_scan (
    .i_CLK   (i_CLK),
    .i_RSTn  (i_RSTn),
    .i_START (w_start),
    .i_MODE  (r_op == OP_ONEHOT),
    .i_VEC   (r_vec),
    .o_DONE  (w_scan_done),
    .o_COUNT (w_scan_count),
    .o_ERR   (w_scan_err)
  );
`endif

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_y     <= '0;
      r_flags <= '0;
`ifdef ALU_SERIAL_EN
      r_op    <= OP_SUB;
      r_vec   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (r_state == ST_DONE && i_READY) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
          if (w_accept) begin
`ifdef ALU_SERIAL_EN
            r_op  <= i_OP;
            r_vec <= {i_B, i_A};
            if (w_is_scan) begin
              r_state <= ST_BUSY;
              r_valid <= 1'b0;
            end else
`endif
            begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
              r_y     <= w_imm_y;
              r_flags <= w_imm_flags;
            end
          end
        end
`ifdef ALU_SERIAL_EN
        ST_BUSY: begin
          if (w_scan_done) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
            r_y     <= w_scan_count;
            r_flags <= f_flags(w_scan_count, 1'b0, 1'b0,
                               (r_op == OP_ONEHOT) & w_scan_err);
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Operation stage of the basic ALU pipeline, placed directly upstream of the `cpreg` ready/valid pipeline register. It accepts one operand pair and an opcode per transaction and computes one of four operations: subtract, NAND, leading-ones count of {B,A}, or one-hot decode of {B,A}. It then holds the result and flags on its output until the downstream register takes them. The two bit-scan operations run serially, one bit per cycle, so latency depends on the data.

## Interface
- `WIDTH`, 4: operand and result width. Must be ≥ 3 so that counts up to 2·WIDTH fit.
- `i_CLK` in 1: clock, rising edge.
- `i_RSTn` in 1: reset, asynchronous, active-low.
- `i_VALID` in 1: upstream offers a transaction.
- `o_READY` out 1: stage can accept a transaction.
- `i_A`, `i_B` in WIDTH: operands, signed two's complement.
- `i_OP` in 2: opcode. 00 SUB, 01 NAND, 10 LONES, 11 ONEHOT.
- `o_VALID` out 1: result available.
- `i_READY` in 1: downstream (`cpreg` `o_READY`) accepts.
- `o_Y` out WIDTH: result.
- `o_FLAGS` out 4: flag bits {ERR, OVF, NEG, ZERO}, bits [3:0].

## Operation
- FSM states:
  - IDLE: o_READY=1, o_VALID=0.
  - BUSY: serial scan; o_READY=0, o_VALID=0.
  - DONE: o_VALID=1; o_READY=i_READY.
- Accept: on a rising edge with i_VALID & o_READY, capture A, B and OP.
  - SUB or NAND: go to DONE.
  - LONES or ONEHOT: go to BUSY, scan index = 2·WIDTH−1, count = 0.
- SUB: Y = A − B, WIDTH-bit wraparound. OVF = signed overflow, i.e. operand signs differ and result sign ≠ A sign.
- NAND: Y = ~(A & B). OVF = 0.
- LONES: scan C = {B,A} from the MSB, one bit per BUSY cycle.
  - Bit = 1: increment count.
  - Bit = 0, or index = 0: go to DONE.
  - Y = count, range 0..2·WIDTH.
- ONEHOT: scan all 2·WIDTH bits of {B,A}, one per cycle.
  - On each 1: if a 1 was already seen, set ERR. In all cases Y ← index.
  - Final Y = index of the lowest set bit.
  - No bit set: Y = 0, ERR = 0.
- Flags are computed when entering DONE:
  - ZERO = (Y == 0).
  - NEG = Y[WIDTH−1] for SUB/NAND only, otherwise 0.
  - ERR is set for ONEHOT only.
- DONE with i_READY=1: the result is consumed.
  - If i_VALID=1 in the same cycle, accept the new transaction back-to-back (same edge).
  - Otherwise go to IDLE.
- DONE with i_READY=0: o_Y, o_FLAGS and o_VALID stay stable.
- Inputs i_A, i_B and i_OP are ignored outside acceptance edges.

## Timing
- Reset (asynchronous, any state, including mid-scan): state → IDLE, o_VALID=0, o_Y=0, o_FLAGS=0, scan count/index = 0. o_READY=1 after reset.
- SUB/NAND latency: o_VALID rises 1 cycle after the acceptance edge.
- LONES latency: 1 + min(n+1, 2·WIDTH) cycles, where n = number of leading ones.
- ONEHOT latency: 1 + 2·WIDTH cycles, fixed.
- Throughput: at most one transaction per cycle (SUB/NAND with i_READY held high).
- o_READY depends combinationally on i_READY in DONE only. No other combinational path from input to output.

## Configuration
- Macro `ALU_SERIAL_EN`.
- Defined: LONES and ONEHOT use the serial BUSY scan described above.
- Undefined:
  - LONES and ONEHOT are computed combinationally at acceptance, with the same results and flags.
  - All opcodes have latency 1.
  - BUSY is never entered; the scan counter is not synthesised.

## Structure
- Package `alu_pkg`:
  - Opcode constants `OP_SUB`, `OP_NAND`, `OP_LONES`, `OP_ONEHOT`.
  - Flag bit indices `FLG_ZERO`..`FLG_ERR`.
  - FSM state encodings.
- Sub-module `alu_bit_scanner`:
  - Holds the index down-counter, the ones count and the seen-one/err tracking.
  - Ports: start, mode, vector, done, count, err.
  - Instantiated only under `ALU_SERIAL_EN`.

## Test plan
- SUB, WIDTH=4, A=0111, B=1111 (7 − (−1)) → Y=1000, OVF=1, NEG=1, ZERO=0, o_VALID 1 cycle after acceptance.
- NAND, A=1111, B=1111 → Y=0000, ZERO=1. Hold i_READY=0 for 5 cycles → outputs stable, o_READY=0. Then release → transaction consumed.
- LONES, {B,A}=1110_0000 → Y=3. LONES, {B,A}=1111_1111 → Y=8. Check latency is 5 cycles and 9 cycles respectively with `ALU_SERIAL_EN` defined, 1 cycle without.
- ONEHOT, {B,A}=0010_0000 → Y=5, ERR=0. {B,A}=0100_0100 → Y=2, ERR=1. {B,A}=0 → Y=0, ERR=0, ZERO=1.
- Back-to-back SUB stream with i_READY=1 → one result per cycle, with no bubble after the first.
- Assert i_RSTn=0 mid-LONES scan → o_VALID=0, o_Y=0, o_FLAGS=0 immediately. After release, the next SUB completes normally.
